// File: rtl/display_page_sel_pkg.sv
// Shared definitions for the display-select blocks: page-index width helper and
// default timing constants for a 100 MHz board clock.
package display_page_sel_pkg;

    localparam int DEF_DB_CNT      = 1_000_000;    // 10 ms button settle time
    localparam int DEF_AUTO_PERIOD = 100_000_000;  // 1 s between auto-advances

    // Who caused a page update; only user-driven changes restart the auto period.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_USER,
        SRC_AUTO
    } page_src_e;

    function automatic int page_w(input int num_pages);
        return (num_pages <= 2) ? 1 : $clog2(num_pages);
    endfunction

endpackage

// File: rtl/display_page_sel_btn_debounce.sv
// Raw button conditioning: 2-FF synchroniser, stable-level debouncer and a
// single-cycle pulse on the debounced press edge.
module btn_debounce
    import display_page_sel_pkg::*;
#(
    parameter int DB_CNT = DEF_DB_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int                CNT_W    = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CNT - 1);

    logic [1:0]       sync;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // which is what makes the synchroniser chain two stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/display_page_sel.sv
// Debug-view page selector: arbitrates load, next/prev buttons and timed
// auto-advance into a registered page index with change/wrap pulses.
module display_page_sel
    import display_page_sel_pkg::*;
#(
    parameter int NUM_PAGES   = 4,
    parameter int PAGE_W      = page_w(NUM_PAGES),
    parameter int DB_CNT      = DEF_DB_CNT,
    parameter int AUTO_PERIOD = DEF_AUTO_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    input  logic              load_en,
    input  logic [PAGE_W-1:0] load_page,
    output logic [PAGE_W-1:0] page,
    output logic              page_chg,
    output logic              wrapped
);

    localparam logic [PAGE_W-1:0] LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [PAGE_W:0]   PAGE_LIMIT = (PAGE_W + 1)'(NUM_PAGES);
    localparam int                TMR_W      = $clog2(AUTO_PERIOD);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(AUTO_PERIOD - 1);

    logic              next_p;
    logic              prev_p;
    logic              auto_tick;
    logic [TMR_W-1:0]  timer;
    logic [PAGE_W-1:0] page_nxt;
    logic              chg_nxt;
    logic              wrap_nxt;
    page_src_e         src;

    btn_debounce #(.DB_CNT(DB_CNT)) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .rise  (next_p)
    );

    btn_debounce #(.DB_CNT(DB_CNT)) u_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_prev),
        .rise  (prev_p)
    );

    // Returns {wrap, new_page}; wrap-around keeps non-power-of-2 counts in range.
    function automatic logic [PAGE_W:0] step(input logic [PAGE_W-1:0] p, input logic fwd);
        if (fwd)
            return (p == LAST_PAGE) ? {1'b1, {PAGE_W{1'b0}}} : {1'b0, p + 1'b1};
        else
            return (p == '0) ? {1'b1, LAST_PAGE} : {1'b0, p - 1'b1};
    endfunction

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        page_nxt  = page;
        wrap_nxt  = 1'b0;
        src       = SRC_NONE;
        auto_tick = auto_en && (timer == TMR_LAST);

        if (load_en && ({1'b0, load_page} < PAGE_LIMIT)) begin
            page_nxt = load_page;
            src      = SRC_USER;
        end else if (next_p && prev_p) begin
            src = SRC_NONE;  // opposing presses cancel
        end else if (next_p) begin
            {wrap_nxt, page_nxt} = step(page, 1'b1);
            src                  = SRC_USER;
        end else if (prev_p) begin
            {wrap_nxt, page_nxt} = step(page, 1'b0);
            src                  = SRC_USER;
        end else if (auto_tick) begin
            {wrap_nxt, page_nxt} = step(page, 1'b1);
            src                  = SRC_AUTO;
        end

        chg_nxt = (page_nxt != page);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page     <= '0;
            page_chg <= 1'b0;
            wrapped  <= 1'b0;
            timer    <= '0;
        end else begin
            page     <= page_nxt;
            page_chg <= chg_nxt;
            wrapped  <= wrap_nxt;
            if (!auto_en || auto_tick || (src == SRC_USER && chg_nxt))
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

endmodule
